// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//
// Circular reorder buffer for a dual-issue out-of-order core.
//   - Allocates up to two entries per cycle from rename (slot 0 is older).
//   - Accepts up to three completion writebacks per cycle.
//   - Retires up to two completed entries per cycle, in program order.
//   - Exports a per-entry forwarding table {to_fwd, val} for dispatch/issue.
//
// Ports
//   clk_i, rst_i                       clock, async active-high reset
//   allocN_en_i/pdest_i/old_pdest_i/
//   regwrite_i/pc_i                    allocation request, slots 0 and 1
//   rob_index0_o / rob_index1_o        entry indices for this cycle's allocs
//   full_o / empty_o / count_o         occupancy status
//   en/index/val_complete_instrN_i     completion ports 0..2
//   en_retireN_o, retire_pcN_o,
//   reg_writeN_o, destN_o, wordN_o,
//   en_free_regN_o, free_regN_o        registered retirement outputs
//   rob_fwd_table_o                    entry i at [i*(W+1) +: W+1] = {to_fwd,val}
// -----------------------------------------------------------------------------
module reorder_buffer #(
   parameter int WORD_SIZE  = 32,
   parameter int PC_SIZE    = 32,
   parameter int NUM_P_REGS = 64,
   parameter int ROB_SIZE   = 16,
   localparam int PW = $clog2(NUM_P_REGS),
   localparam int IW = $clog2(ROB_SIZE)
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   // allocation
   input  logic                              alloc0_en_i,
   input  logic [PW-1:0]                     alloc0_pdest_i,
   input  logic [PW-1:0]                     alloc0_old_pdest_i,
   input  logic                              alloc0_regwrite_i,
   input  logic [PC_SIZE-1:0]                alloc0_pc_i,
   input  logic                              alloc1_en_i,
   input  logic [PW-1:0]                     alloc1_pdest_i,
   input  logic [PW-1:0]                     alloc1_old_pdest_i,
   input  logic                              alloc1_regwrite_i,
   input  logic [PC_SIZE-1:0]                alloc1_pc_i,
   output logic [IW-1:0]                     rob_index0_o,
   output logic [IW-1:0]                     rob_index1_o,
   output logic                              full_o,
   output logic                              empty_o,
   output logic [IW:0]                       count_o,
   // completion
   input  logic                              en_complete_instr0_i,
   input  logic [IW-1:0]                     index_complete_instr0_i,
   input  logic [WORD_SIZE-1:0]              val_complete_instr0_i,
   input  logic                              en_complete_instr1_i,
   input  logic [IW-1:0]                     index_complete_instr1_i,
   input  logic [WORD_SIZE-1:0]              val_complete_instr1_i,
   input  logic                              en_complete_instr2_i,
   input  logic [IW-1:0]                     index_complete_instr2_i,
   input  logic [WORD_SIZE-1:0]              val_complete_instr2_i,
   // retirement
   output logic                              en_retire0_o,
   output logic [PC_SIZE-1:0]                retire_pc0_o,
   output logic                              reg_write0_o,
   output logic [PW-1:0]                     dest0_o,
   output logic [WORD_SIZE-1:0]              word0_o,
   output logic                              en_free_reg0_o,
   output logic [PW-1:0]                     free_reg0_o,
   output logic                              en_retire1_o,
   output logic [PC_SIZE-1:0]                retire_pc1_o,
   output logic                              reg_write1_o,
   output logic [PW-1:0]                     dest1_o,
   output logic [WORD_SIZE-1:0]              word1_o,
   output logic                              en_free_reg1_o,
   output logic [PW-1:0]                     free_reg1_o,
   // forwarding table
   output logic [ROB_SIZE*(WORD_SIZE+1)-1:0] rob_fwd_table_o
);

   localparam logic [IW:0] FULL_LVL = (IW+1)'(ROB_SIZE - 1);

   // entry storage
   logic                 valid_q    [ROB_SIZE];
   logic                 valid_d    [ROB_SIZE];
   logic                 done_q     [ROB_SIZE];
   logic                 done_d     [ROB_SIZE];
   logic                 regwrite_q [ROB_SIZE];
   logic                 regwrite_d [ROB_SIZE];
   logic [PW-1:0]        pdest_q    [ROB_SIZE];
   logic [PW-1:0]        pdest_d    [ROB_SIZE];
   logic [PW-1:0]        old_q      [ROB_SIZE];
   logic [PW-1:0]        old_d      [ROB_SIZE];
   logic [PC_SIZE-1:0]   pc_q       [ROB_SIZE];
   logic [PC_SIZE-1:0]   pc_d       [ROB_SIZE];
   logic [WORD_SIZE-1:0] val_q      [ROB_SIZE];
   logic [WORD_SIZE-1:0] val_d      [ROB_SIZE];

   logic [IW-1:0] head_q, head_d, tail_q, tail_d;
   logic [IW:0]   count_q, count_d;

   // registered retirement outputs
   logic                 ret0_q, ret0_d, ret1_q, ret1_d;
   logic                 rw0_q, rw0_d, rw1_q, rw1_d;
   logic [PC_SIZE-1:0]   rpc0_q, rpc0_d, rpc1_q, rpc1_d;
   logic [PW-1:0]        dst0_q, dst0_d, dst1_q, dst1_d;
   logic [PW-1:0]        frg0_q, frg0_d, frg1_q, frg1_d;
   logic [WORD_SIZE-1:0] wrd0_q, wrd0_d, wrd1_q, wrd1_d;

   // completion ports gathered into arrays
   logic                 cmp_en  [3];
   logic [IW-1:0]        cmp_idx [3];
   logic [WORD_SIZE-1:0] cmp_val [3];

   logic          full_s;
   logic [IW-1:0] head_p1_s, tail_p1_s, idx1_s;
   logic          acc0_s, acc1_s, r0_s, r1_s;
   logic [1:0]    alloc_n_s, ret_n_s;

   assign cmp_en[0]  = en_complete_instr0_i;
   assign cmp_en[1]  = en_complete_instr1_i;
   assign cmp_en[2]  = en_complete_instr2_i;
   assign cmp_idx[0] = index_complete_instr0_i;
   assign cmp_idx[1] = index_complete_instr1_i;
   assign cmp_idx[2] = index_complete_instr2_i;
   assign cmp_val[0] = val_complete_instr0_i;
   assign cmp_val[1] = val_complete_instr1_i;
   assign cmp_val[2] = val_complete_instr2_i;

   // full is conservative: same-cycle retirement is not credited
   assign full_s    = (count_q >= FULL_LVL);
   assign head_p1_s = head_q + {{(IW-1){1'b0}}, 1'b1};
   assign tail_p1_s = tail_q + {{(IW-1){1'b0}}, 1'b1};
   // slot 1 takes the next entry only when slot 0 also allocates
   assign idx1_s    = alloc0_en_i ? tail_p1_s : tail_q;
   assign acc0_s    = alloc0_en_i && !full_s;
   assign acc1_s    = alloc1_en_i && !full_s;
   assign r0_s      = valid_q[head_q] && done_q[head_q];
   assign r1_s      = r0_s && valid_q[head_p1_s] && done_q[head_p1_s];
   assign alloc_n_s = {1'b0, acc0_s} + {1'b0, acc1_s};
   assign ret_n_s   = {1'b0, r0_s} + {1'b0, r1_s};

   // next-state for entries, pointers, count and retirement outputs
   always_comb begin
      valid_d    = valid_q;
      done_d     = done_q;
      regwrite_d = regwrite_q;
      pdest_d    = pdest_q;
      old_d      = old_q;
      pc_d       = pc_q;
      val_d      = val_q;

      // completions: iterate high to low so the lowest port wins a collision
      for (int p = 2; p >= 0; p--) begin
         if (cmp_en[p] && valid_q[cmp_idx[p]]) begin
            done_d[cmp_idx[p]] = 1'b1;
            val_d[cmp_idx[p]]  = cmp_val[p];
         end else begin
            done_d[cmp_idx[p]] = done_d[cmp_idx[p]];
         end
      end

      // retirement, decided on pre-edge done bits
      if (r0_s) begin
         valid_d[head_q] = 1'b0;
         done_d[head_q]  = 1'b0;
      end else begin
         valid_d[head_q] = valid_d[head_q];
      end
      if (r1_s) begin
         valid_d[head_p1_s] = 1'b0;
         done_d[head_p1_s]  = 1'b0;
      end else begin
         valid_d[head_p1_s] = valid_d[head_p1_s];
      end

      // allocation only ever lands on free entries
      if (acc0_s) begin
         valid_d[tail_q]    = 1'b1;
         done_d[tail_q]     = 1'b0;
         val_d[tail_q]      = {WORD_SIZE{1'b0}};
         regwrite_d[tail_q] = alloc0_regwrite_i;
         pdest_d[tail_q]    = alloc0_pdest_i;
         old_d[tail_q]      = alloc0_old_pdest_i;
         pc_d[tail_q]       = alloc0_pc_i;
      end else begin
         valid_d[tail_q] = valid_d[tail_q];
      end
      if (acc1_s) begin
         valid_d[idx1_s]    = 1'b1;
         done_d[idx1_s]     = 1'b0;
         val_d[idx1_s]      = {WORD_SIZE{1'b0}};
         regwrite_d[idx1_s] = alloc1_regwrite_i;
         pdest_d[idx1_s]    = alloc1_pdest_i;
         old_d[idx1_s]      = alloc1_old_pdest_i;
         pc_d[idx1_s]       = alloc1_pc_i;
      end else begin
         valid_d[idx1_s] = valid_d[idx1_s];
      end

      head_d  = head_q + IW'(ret_n_s);
      tail_d  = tail_q + IW'(alloc_n_s);
      count_d = count_q + (IW+1)'(alloc_n_s) - (IW+1)'(ret_n_s);

      ret0_d = r0_s;
      rw0_d  = r0_s && regwrite_q[head_q];
      rpc0_d = r0_s ? pc_q[head_q]    : {PC_SIZE{1'b0}};
      dst0_d = r0_s ? pdest_q[head_q] : {PW{1'b0}};
      frg0_d = r0_s ? old_q[head_q]   : {PW{1'b0}};
      wrd0_d = r0_s ? val_q[head_q]   : {WORD_SIZE{1'b0}};
      ret1_d = r1_s;
      rw1_d  = r1_s && regwrite_q[head_p1_s];
      rpc1_d = r1_s ? pc_q[head_p1_s]    : {PC_SIZE{1'b0}};
      dst1_d = r1_s ? pdest_q[head_p1_s] : {PW{1'b0}};
      frg1_d = r1_s ? old_q[head_p1_s]   : {PW{1'b0}};
      wrd1_d = r1_s ? val_q[head_p1_s]   : {WORD_SIZE{1'b0}};
   end

   // state registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < ROB_SIZE; i++) begin
            valid_q[i]    <= 1'b0;
            done_q[i]     <= 1'b0;
            regwrite_q[i] <= 1'b0;
            pdest_q[i]    <= {PW{1'b0}};
            old_q[i]      <= {PW{1'b0}};
            pc_q[i]       <= {PC_SIZE{1'b0}};
            val_q[i]      <= {WORD_SIZE{1'b0}};
         end
         head_q  <= {IW{1'b0}};
         tail_q  <= {IW{1'b0}};
         count_q <= {(IW+1){1'b0}};
         ret0_q  <= 1'b0;
         rw0_q   <= 1'b0;
         rpc0_q  <= {PC_SIZE{1'b0}};
         dst0_q  <= {PW{1'b0}};
         frg0_q  <= {PW{1'b0}};
         wrd0_q  <= {WORD_SIZE{1'b0}};
         ret1_q  <= 1'b0;
         rw1_q   <= 1'b0;
         rpc1_q  <= {PC_SIZE{1'b0}};
         dst1_q  <= {PW{1'b0}};
         frg1_q  <= {PW{1'b0}};
         wrd1_q  <= {WORD_SIZE{1'b0}};
      end else begin
         valid_q    <= valid_d;
         done_q     <= done_d;
         regwrite_q <= regwrite_d;
         pdest_q    <= pdest_d;
         old_q      <= old_d;
         pc_q       <= pc_d;
         val_q      <= val_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         ret0_q     <= ret0_d;
         rw0_q      <= rw0_d;
         rpc0_q     <= rpc0_d;
         dst0_q     <= dst0_d;
         frg0_q     <= frg0_d;
         wrd0_q     <= wrd0_d;
         ret1_q     <= ret1_d;
         rw1_q      <= rw1_d;
         rpc1_q     <= rpc1_d;
         dst1_q     <= dst1_d;
         frg1_q     <= frg1_d;
         wrd1_q     <= wrd1_d;
      end
   end

   // forwarding table: {to_fwd, val} per entry
   always_comb begin
      rob_fwd_table_o = {(ROB_SIZE*(WORD_SIZE+1)){1'b0}};
      for (int i = 0; i < ROB_SIZE; i++) begin
         rob_fwd_table_o[i*(WORD_SIZE+1) +: (WORD_SIZE+1)] =
            {valid_q[i] && done_q[i], val_q[i]};
      end
   end

   assign rob_index0_o   = tail_q;
   assign rob_index1_o   = idx1_s;
   assign full_o         = full_s;
   assign empty_o        = (count_q == {(IW+1){1'b0}});
   assign count_o        = count_q;
   assign en_retire0_o   = ret0_q;
   assign retire_pc0_o   = rpc0_q;
   assign reg_write0_o   = rw0_q;
   assign dest0_o        = dst0_q;
   assign word0_o        = wrd0_q;
   assign en_free_reg0_o = rw0_q;
   assign free_reg0_o    = frg0_q;
   assign en_retire1_o   = ret1_q;
   assign retire_pc1_o   = rpc1_q;
   assign reg_write1_o   = rw1_q;
   assign dest1_o        = dst1_q;
   assign word1_o        = wrd1_q;
   assign en_free_reg1_o = rw1_q;
   assign free_reg1_o    = frg1_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// -----------------------------------------------------------------------------
// tb_reorder_buffer
//
// Directed self-checking bench for reorder_buffer with default parameters
// (32-bit words/PCs, 64 physical regs, 16 entries).
// -----------------------------------------------------------------------------
module tb_reorder_buffer;

   localparam int W  = 32;
   localparam int PW = 6;
   localparam int IW = 4;
   localparam int N  = 16;
   localparam int TW = N * (W + 1);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          a0_en, a1_en, a0_rw, a1_rw;
   logic [PW-1:0] a0_pd, a1_pd, a0_old, a1_old;
   logic [31:0]   a0_pc, a1_pc;
   logic [IW-1:0] idx0, idx1;
   logic          full, empty;
   logic [IW:0]   count;
   logic          c0_en, c1_en, c2_en;
   logic [IW-1:0] c0_idx, c1_idx, c2_idx;
   logic [W-1:0]  c0_val, c1_val, c2_val;
   logic          er0, er1, rw0, rw1, ef0, ef1;
   logic [31:0]   rpc0, rpc1;
   logic [PW-1:0] d0, d1, fr0, fr1;
   logic [W-1:0]  w0, w1;
   logic [TW-1:0] fwd, snap;

   int total = 0;
   int bad   = 0;

   reorder_buffer dut (
      .clk_i(clk), .rst_i(rst),
      .alloc0_en_i(a0_en), .alloc0_pdest_i(a0_pd), .alloc0_old_pdest_i(a0_old),
      .alloc0_regwrite_i(a0_rw), .alloc0_pc_i(a0_pc),
      .alloc1_en_i(a1_en), .alloc1_pdest_i(a1_pd), .alloc1_old_pdest_i(a1_old),
      .alloc1_regwrite_i(a1_rw), .alloc1_pc_i(a1_pc),
      .rob_index0_o(idx0), .rob_index1_o(idx1),
      .full_o(full), .empty_o(empty), .count_o(count),
      .en_complete_instr0_i(c0_en), .index_complete_instr0_i(c0_idx), .val_complete_instr0_i(c0_val),
      .en_complete_instr1_i(c1_en), .index_complete_instr1_i(c1_idx), .val_complete_instr1_i(c1_val),
      .en_complete_instr2_i(c2_en), .index_complete_instr2_i(c2_idx), .val_complete_instr2_i(c2_val),
      .en_retire0_o(er0), .retire_pc0_o(rpc0), .reg_write0_o(rw0), .dest0_o(d0),
      .word0_o(w0), .en_free_reg0_o(ef0), .free_reg0_o(fr0),
      .en_retire1_o(er1), .retire_pc1_o(rpc1), .reg_write1_o(rw1), .dest1_o(d1),
      .word1_o(w1), .en_free_reg1_o(ef1), .free_reg1_o(fr1),
      .rob_fwd_table_o(fwd)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_tbl(input string tag, input logic [TW-1:0] exp);
      total++;
      assert (fwd === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, fwd, exp);
      end
   endtask

   function automatic logic [W:0] ent(input int i);
      return fwd[i*(W+1) +: (W+1)];
   endfunction

   // step to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      a0_en = 1'b0; a1_en = 1'b0;
      c0_en = 1'b0; c1_en = 1'b0; c2_en = 1'b0;
   endtask

   task automatic alloc(input logic e0, input logic [PW-1:0] pd0, input logic [PW-1:0] o0,
                        input logic r0, input logic [31:0] pc0,
                        input logic e1, input logic [PW-1:0] pd1, input logic [PW-1:0] o1,
                        input logic r1, input logic [31:0] pc1);
      a0_en = e0; a0_pd = pd0; a0_old = o0; a0_rw = r0; a0_pc = pc0;
      a1_en = e1; a1_pd = pd1; a1_old = o1; a1_rw = r1; a1_pc = pc1;
   endtask

   task automatic comp(input int port, input logic [IW-1:0] i, input logic [W-1:0] v);
      case (port)
         0: begin c0_en = 1'b1; c0_idx = i; c0_val = v; end
         1: begin c1_en = 1'b1; c1_idx = i; c1_val = v; end
         default: begin c2_en = 1'b1; c2_idx = i; c2_val = v; end
      endcase
   endtask

   // drain everything with a bounded wait
   task automatic drain(input string tag);
      int guard = 0;
      idle();
      while (!empty && guard < 40) begin
         tick();
         guard++;
      end
      chk(tag, {63'd0, empty}, 64'd1);
   endtask

   initial begin
      idle();
      alloc(1'b0, 6'd0, 6'd0, 1'b0, 32'd0, 1'b0, 6'd0, 6'd0, 1'b0, 32'd0);
      c0_idx = 4'd0; c1_idx = 4'd0; c2_idx = 4'd0;
      c0_val = 32'd0; c1_val = 32'd0; c2_val = 32'd0;
      tick(); tick();
      rst = 1'b0;
      #1;

      // ---- reset state
      chk("rst_empty", {63'd0, empty}, 64'd1);
      chk("rst_full", {63'd0, full}, 64'd0);
      chk("rst_count", {59'd0, count}, 64'd0);
      chk("rst_ret", {58'd0, er0, er1, rw0, rw1, ef0, ef1}, 64'd0);
      chk("rst_fields", {d0, d1, fr0, fr1, w0}, 64'd0);
      chk_tbl("rst_tbl", {TW{1'b0}});

      // ---- basic pair
      alloc(1'b1, 6'd33, 6'd5, 1'b1, 32'h100, 1'b1, 6'd34, 6'd6, 1'b1, 32'h104);
      #1;
      chk("pair_idx0", {60'd0, idx0}, 64'd0);
      chk("pair_idx1", {60'd0, idx1}, 64'd1);
      tick(); idle();
      chk("pair_count", {59'd0, count}, 64'd2);
      comp(0, 4'd1, 32'hBEEF);
      tick(); idle();
      chk("pair_ent1", {31'd0, ent(1)}, {31'd0, 1'b1, 32'hBEEF});
      chk("pair_noret", {63'd0, er0}, 64'd0);
      comp(0, 4'd0, 32'h1234);
      tick(); idle();
      chk("pair_noret_n", {63'd0, er0}, 64'd0);
      tick();
      chk("pair_er", {62'd0, er0, er1}, 64'd3);
      chk("pair_d0", {58'd0, d0}, 64'd33);
      chk("pair_w0", {32'd0, w0}, 64'h1234);
      chk("pair_fr0", {58'd0, fr0}, 64'd5);
      chk("pair_d1", {58'd0, d1}, 64'd34);
      chk("pair_w1", {32'd0, w1}, 64'hBEEF);
      chk("pair_fr1", {58'd0, fr1}, 64'd6);
      chk("pair_wr_free", {60'd0, rw0, rw1, ef0, ef1}, 64'hF);
      chk("pair_pc0", {32'd0, rpc0}, 64'h100);
      chk("pair_count0", {59'd0, count}, 64'd0);
      tick();
      chk("pair_er_hold", {62'd0, er0, er1}, 64'd0);

      // ---- three completions in one cycle, head = 2
      alloc(1'b1, 6'd10, 6'd1, 1'b1, 32'h200, 1'b1, 6'd11, 6'd2, 1'b0, 32'h204);
      #1;
      chk("h2_idx0", {60'd0, idx0}, 64'd2);
      chk("h2_idx1", {60'd0, idx1}, 64'd3);
      tick();
      alloc(1'b1, 6'd12, 6'd3, 1'b1, 32'h208, 1'b1, 6'd13, 6'd4, 1'b1, 32'h20C);
      #1;
      chk("h2_idx2", {60'd0, idx0}, 64'd4);
      tick(); idle();
      chk("h2_count", {59'd0, count}, 64'd4);
      comp(0, 4'd2, 32'h22); comp(1, 4'd3, 32'h33); comp(2, 4'd4, 32'h44);
      tick(); idle();
      chk("h2_fwd", {61'd0, ent(2)[W], ent(3)[W], ent(4)[W]}, 64'd7);
      chk("h2_noret", {63'd0, er0}, 64'd0);
      tick();
      chk("h2_er_a", {62'd0, er0, er1}, 64'd3);
      chk("h2_pc0", {32'd0, rpc0}, 64'h200);
      chk("h2_w0", {32'd0, w0}, 64'h22);
      chk("h2_pc1", {32'd0, rpc1}, 64'h204);
      chk("h2_w1", {32'd0, w1}, 64'h33);
      chk("h2_rw1_off", {62'd0, rw1, ef1}, 64'd0);
      chk("h2_count2", {59'd0, count}, 64'd2);
      comp(0, 4'd5, 32'hA); comp(1, 4'd5, 32'hB);
      tick(); idle();
      chk("h2_er_b", {62'd0, er0, er1}, 64'd2);
      chk("h2_w0b", {32'd0, w0}, 64'h44);
      chk("h2_pc1b", {32'd0, rpc1}, 64'h0);
      chk("h2_collide", {31'd0, ent(5)}, {31'd0, 1'b1, 32'hA});
      tick();
      chk("h2_er_c", {63'd0, er0}, 64'd1);
      chk("h2_w0c", {32'd0, w0}, 64'hA);
      chk("h2_d0c", {58'd0, d0}, 64'd13);
      chk("h2_count0", {59'd0, count}, 64'd0);

      // ---- fill to full (head = tail = 6)
      for (int k = 0; k < 8; k++) begin
         alloc(1'b1, 6'(k), 6'd0, 1'b1, 32'(k), 1'b1, 6'(k + 20), 6'd0, 1'b1, 32'(k + 20));
         tick();
         if (k == 6) begin
            chk("fill7_count", {59'd0, count}, 64'd14);
            chk("fill7_full", {63'd0, full}, 64'd0);
         end
      end
      idle();
      chk("fill8_count", {59'd0, count}, 64'd16);
      chk("fill8_full", {63'd0, full}, 64'd1);
      chk("fill8_empty", {63'd0, empty}, 64'd0);
      snap = fwd;
      alloc(1'b1, 6'd60, 6'd61, 1'b1, 32'hDEAD, 1'b1, 6'd62, 6'd63, 1'b1, 32'hBEEF);
      #1;
      chk("fill9_idx", {60'd0, idx0}, 64'd6);
      tick(); idle();
      chk("fill9_count", {59'd0, count}, 64'd16);
      chk_tbl("fill9_tbl", snap);
      for (int k = 0; k < 16; k++) begin
         comp(0, 4'(6 + k), 32'(k + 1));
         tick();
      end
      drain("fill_drain");

      // ---- walk head/tail to 15
      for (int k = 0; k < 9; k++) begin
         alloc(1'b1, 6'd1, 6'd2, 1'b0, 32'h300, 1'b0, 6'd0, 6'd0, 1'b0, 32'd0);
         tick();
      end
      idle();
      for (int k = 0; k < 9; k++) begin
         comp(0, 4'(6 + k), 32'd0);
         tick();
      end
      drain("walk_drain");

      // ---- wrap-around
      alloc(1'b1, 6'd40, 6'd41, 1'b1, 32'hF00, 1'b1, 6'd42, 6'd43, 1'b1, 32'hF04);
      #1;
      chk("wrap_idx0", {60'd0, idx0}, 64'd15);
      chk("wrap_idx1", {60'd0, idx1}, 64'd0);
      tick(); idle();
      #1;
      chk("wrap_tail", {60'd0, idx0}, 64'd1);
      comp(0, 4'd0, 32'h0); comp(1, 4'd15, 32'hF);
      tick(); idle();
      tick();
      chk("wrap_er", {62'd0, er0, er1}, 64'd3);
      chk("wrap_pc0", {32'd0, rpc0}, 64'hF00);
      chk("wrap_pc1", {32'd0, rpc1}, 64'hF04);
      chk("wrap_w0", {32'd0, w0}, 64'hF);
      chk("wrap_count", {59'd0, count}, 64'd0);

      // ---- asynchronous reset mid-operation
      alloc(1'b1, 6'd1, 6'd2, 1'b1, 32'h400, 1'b1, 6'd3, 6'd4, 1'b1, 32'h404);
      tick(); tick();
      alloc(1'b1, 6'd5, 6'd6, 1'b1, 32'h408, 1'b0, 6'd0, 6'd0, 1'b0, 32'd0);
      tick(); idle();
      chk("ar_count5", {59'd0, count}, 64'd5);
      comp(0, 4'd1, 32'h77);
      tick(); idle();
      chk("ar_done1", {63'd0, ent(1)[W]}, 64'd1);
      rst = 1'b1;
      #1;
      chk("ar_count", {59'd0, count}, 64'd0);
      chk("ar_empty", {63'd0, empty}, 64'd1);
      chk_tbl("ar_tbl", {TW{1'b0}});
      chk("ar_er", {62'd0, er0, er1}, 64'd0);
      rst = 1'b0;
      #1;
      comp(0, 4'd0, 32'h55);
      tick(); idle();
      chk_tbl("ar_cmp_drop", {TW{1'b0}});
      chk("ar_er_a", {62'd0, er0, er1}, 64'd0);
      tick();
      chk("ar_er_b", {62'd0, er0, er1}, 64'd0);
      chk("ar_count_end", {59'd0, count}, 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // hard time bound so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
